// File: rtl/weight_buffer_loader.sv
// ============================================================================
// Module      : weight_buffer_loader
// Description : Turns a valid/ready stream of 64-bit weight words into write
//               requests for the weight line buffers. Each word is placed in
//               order: bank first, then address, then buffer. The module
//               pulses done together with the last write.
//               Optional bias loading is enabled by WEIGHT_BUFFER_LOADER_BIAS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_buffer_loader #(
  parameter int WEIGHT_BANK_BIT_WIDTH         = 64,
  parameter int WEIGHT_BUFFER_BANK_COUNT      = 8,
  parameter int WEIGHT_LINE_BUFFER_DEPTH      = 512,
  parameter int NUMBER_OF_WEIGHT_LINE_BUFFERS = 6,
  parameter int BIAS_LINE_BUFFER_DEPTH        = 32,
  parameter int BIAS_BUFFER_BANK_COUNT        = 4,
  parameter int BIAS_BANK_BIT_WIDTH           = 64
) (
  input  logic                                          clk,
  input  logic                                          resetn,
  input  logic                                          start,
  input  logic                                          soft_clear,
  input  logic [$clog2(WEIGHT_LINE_BUFFER_DEPTH)-1:0]   cfg_line_count_m1,
  input  logic [$clog2(NUMBER_OF_WEIGHT_LINE_BUFFERS)-1:0] cfg_buffer_count_m1,
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
  input  logic [$clog2(BIAS_LINE_BUFFER_DEPTH)-1:0]     cfg_bias_count_m1,
`endif
  input  logic [WEIGHT_BANK_BIT_WIDTH-1:0]              s_data,
  input  logic                                          s_valid,
  output logic                                          s_ready,
  output logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0]      write_port_enable,
  output logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0][WEIGHT_BANK_BIT_WIDTH-1:0]     write_port_data_in,
  output logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0][WEIGHT_BUFFER_BANK_COUNT-1:0]  write_port_wen,
  output logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0][$clog2(WEIGHT_LINE_BUFFER_DEPTH)-1:0] write_port_addr,
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
  output logic                                          bias_write_port_enable,
  output logic [BIAS_BANK_BIT_WIDTH-1:0]                bias_write_port_data_in,
  output logic [BIAS_BUFFER_BANK_COUNT-1:0]             bias_write_port_wen,
  output logic [$clog2(BIAS_LINE_BUFFER_DEPTH)-1:0]     bias_write_port_addr,
`endif
  output logic                                          busy,
  output logic                                          done
);

  localparam int LINE_W = $clog2(WEIGHT_LINE_BUFFER_DEPTH);
  localparam int BUF_W  = $clog2(NUMBER_OF_WEIGHT_LINE_BUFFERS);
  localparam int BANK_W = $clog2(WEIGHT_BUFFER_BANK_COUNT);
  localparam logic [WEIGHT_BUFFER_BANK_COUNT-1:0] WEN_ONE = {{(WEIGHT_BUFFER_BANK_COUNT-1){1'b0}}, 1'b1};

`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
  localparam int BLINE_W = $clog2(BIAS_LINE_BUFFER_DEPTH);
  localparam int BBANK_W = $clog2(BIAS_BUFFER_BANK_COUNT);
  localparam logic [BIAS_BUFFER_BANK_COUNT-1:0] BWEN_ONE = {{(BIAS_BUFFER_BANK_COUNT-1){1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_W = 2'd1, LOAD_B = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD_W = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t                  state_q;
  logic                    s_ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic [LINE_W-1:0]       cfg_line_m1_q;
  logic [BUF_W-1:0]        cfg_buf_m1_q;
  logic [BANK_W-1:0]       bank_cnt_q;
  logic [LINE_W-1:0]       line_cnt_q;
  logic [BUF_W-1:0]        buf_cnt_q;

  logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0]                                wp_en_q;
  logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0][WEIGHT_BANK_BIT_WIDTH-1:0]     wp_data_q;
  logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0][WEIGHT_BUFFER_BANK_COUNT-1:0]  wp_wen_q;
  logic [NUMBER_OF_WEIGHT_LINE_BUFFERS-1:0][LINE_W-1:0]                    wp_addr_q;

  // A beat is only taken when ready is up; soft_clear discards it outright.
  logic w_accept;
  logic w_beat_w;
  logic w_bank_last;
  logic w_line_last;
  logic w_buf_last;

  assign w_accept    = s_valid && s_ready_q && !soft_clear;
  assign w_beat_w    = w_accept && (state_q == LOAD_W);
  assign w_bank_last = (bank_cnt_q == BANK_W'(WEIGHT_BUFFER_BANK_COUNT - 1));
  assign w_line_last = (line_cnt_q == cfg_line_m1_q);
  assign w_buf_last  = (buf_cnt_q == cfg_buf_m1_q);

`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
  logic [BLINE_W-1:0]      cfg_bias_m1_q;
  logic [BBANK_W-1:0]      bias_bank_cnt_q;
  logic [BLINE_W-1:0]      bias_line_cnt_q;
  logic                    bias_en_q;
  logic [BIAS_BANK_BIT_WIDTH-1:0]    bias_data_q;
  logic [BIAS_BUFFER_BANK_COUNT-1:0] bias_wen_q;
  logic [BLINE_W-1:0]      bias_addr_q;
  logic                    w_beat_b;
  logic                    w_bias_bank_last;
  logic                    w_bias_line_last;

  assign w_beat_b         = w_accept && (state_q == LOAD_B);
  assign w_bias_bank_last = (bias_bank_cnt_q == BBANK_W'(BIAS_BUFFER_BANK_COUNT - 1));
  assign w_bias_line_last = (bias_line_cnt_q == cfg_bias_m1_q);
`else
  // Bias parameters only matter when bias loading is built in.
  logic unused_bias_params;
  assign unused_bias_params = (BIAS_LINE_BUFFER_DEPTH + BIAS_BUFFER_BANK_COUNT + BIAS_BANK_BIT_WIDTH) != 0;
`endif

  // Sequencer: config latch, bank/addr/buffer counters and the status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cfg_line_m1_q <= '0;
      cfg_buf_m1_q  <= '0;
      bank_cnt_q    <= '0;
      line_cnt_q    <= '0;
      buf_cnt_q     <= '0;
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
      cfg_bias_m1_q   <= '0;
      bias_bank_cnt_q <= '0;
      bias_line_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (soft_clear) begin
        state_q   <= IDLE;
        s_ready_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              cfg_line_m1_q <= cfg_line_count_m1;
              cfg_buf_m1_q  <= cfg_buffer_count_m1;
              bank_cnt_q    <= '0;
              line_cnt_q    <= '0;
              buf_cnt_q     <= '0;
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
              cfg_bias_m1_q   <= cfg_bias_count_m1;
              bias_bank_cnt_q <= '0;
              bias_line_cnt_q <= '0;
`endif
              state_q       <= LOAD_W;
              s_ready_q     <= 1'b1;
              busy_q        <= 1'b1;
            end
          end
          LOAD_W: begin
            if (w_beat_w) begin
              if (!w_bank_last) begin
                bank_cnt_q <= bank_cnt_q + BANK_W'(1);
              end else begin
                bank_cnt_q <= '0;
                if (!w_line_last) begin
                  line_cnt_q <= line_cnt_q + LINE_W'(1);
                end else begin
                  line_cnt_q <= '0;
                  if (!w_buf_last) begin
                    buf_cnt_q <= buf_cnt_q + BUF_W'(1);
                  end else begin
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
                    state_q <= LOAD_B;
`else
                    state_q   <= DONE;
                    s_ready_q <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
`endif
                  end
                end
              end
            end
          end
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
          LOAD_B: begin
            if (w_beat_b) begin
              if (!w_bias_bank_last) begin
                bias_bank_cnt_q <= bias_bank_cnt_q + BBANK_W'(1);
              end else begin
                bias_bank_cnt_q <= '0;
                if (!w_bias_line_last) begin
                  bias_line_cnt_q <= bias_line_cnt_q + BLINE_W'(1);
                end else begin
                  state_q   <= DONE;
                  s_ready_q <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                end
              end
            end
          end
`endif
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Weight write ports: only the buffer addressed by this beat fires; the rest
  // drop enable/wen but keep their last data and address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp_en_q   <= '0;
      wp_wen_q  <= '0;
      wp_addr_q <= '0;
      wp_data_q <= '0;
    end else begin
      for (int i = 0; i < NUMBER_OF_WEIGHT_LINE_BUFFERS; i++) begin
        if (w_beat_w && (buf_cnt_q == BUF_W'(i))) begin
          wp_en_q[i]   <= 1'b1;
          wp_wen_q[i]  <= WEN_ONE << bank_cnt_q;
          wp_addr_q[i] <= line_cnt_q;
          wp_data_q[i] <= s_data;
        end else begin
          wp_en_q[i]  <= 1'b0;
          wp_wen_q[i] <= '0;
        end
      end
    end
  end

`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
  // Bias write port: same bank-then-address walk, one cycle after the beat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bias_en_q   <= 1'b0;
      bias_wen_q  <= '0;
      bias_addr_q <= '0;
      bias_data_q <= '0;
    end else if (w_beat_b) begin
      bias_en_q   <= 1'b1;
      bias_wen_q  <= BWEN_ONE << bias_bank_cnt_q;
      bias_addr_q <= bias_line_cnt_q;
      bias_data_q <= s_data;
    end else begin
      bias_en_q  <= 1'b0;
      bias_wen_q <= '0;
    end
  end

  assign bias_write_port_enable  = bias_en_q;
  assign bias_write_port_wen     = bias_wen_q;
  assign bias_write_port_addr    = bias_addr_q;
  assign bias_write_port_data_in = bias_data_q;
`endif

  assign s_ready            = s_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign write_port_enable  = wp_en_q;
  assign write_port_wen     = wp_wen_q;
  assign write_port_addr    = wp_addr_q;
  assign write_port_data_in = wp_data_q;

endmodule

`default_nettype wire

// File: tb/tb_weight_buffer_loader.sv
// ============================================================================
// Module      : tb_weight_buffer_loader
// Description : Directed bench for weight_buffer_loader with an expected-write
//               scoreboard derived from the beat index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weight_buffer_loader;

  localparam int N     = 6;
  localparam int W     = 64;
  localparam int BANKS = 8;
  localparam int LW    = 9;
  localparam int BW    = 3;
  localparam int BBANKS = 4;
  localparam int BLW   = 5;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_DONE = 2;

  logic clk;
  logic resetn;
  logic start;
  logic soft_clear;
  logic [LW-1:0] cfg_line_count_m1;
  logic [BW-1:0] cfg_buffer_count_m1;
  logic [W-1:0]  s_data;
  logic          s_valid;
  logic          s_ready;
  logic [N-1:0]  write_port_enable;
  logic [N-1:0][W-1:0]     write_port_data_in;
  logic [N-1:0][BANKS-1:0] write_port_wen;
  logic [N-1:0][LW-1:0]    write_port_addr;
  logic          busy;
  logic          done;
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
  logic [BLW-1:0]    cfg_bias_count_m1;
  logic              bias_write_port_enable;
  logic [W-1:0]      bias_write_port_data_in;
  logic [BBANKS-1:0] bias_write_port_wen;
  logic [BLW-1:0]    bias_write_port_addr;
`endif

  weight_buffer_loader dut (
    .clk                 (clk),
    .resetn              (resetn),
    .start               (start),
    .soft_clear          (soft_clear),
    .cfg_line_count_m1   (cfg_line_count_m1),
    .cfg_buffer_count_m1 (cfg_buffer_count_m1),
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
    .cfg_bias_count_m1   (cfg_bias_count_m1),
`endif
    .s_data              (s_data),
    .s_valid             (s_valid),
    .s_ready             (s_ready),
    .write_port_enable   (write_port_enable),
    .write_port_data_in  (write_port_data_in),
    .write_port_wen      (write_port_wen),
    .write_port_addr     (write_port_addr),
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
    .bias_write_port_enable  (bias_write_port_enable),
    .bias_write_port_data_in (bias_write_port_data_in),
    .bias_write_port_wen     (bias_write_port_wen),
    .bias_write_port_addr    (bias_write_port_addr),
`endif
    .busy                (busy),
    .done                (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          bias;
    int          buf_i;
    int          bank;
    int          addr;
    logic [W-1:0] data;
    bit          last;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int m_state = S_IDLE;
  int m_line = 0;
  int m_buf = 0;
  int m_bias = 0;
  int m_cnt = 0;
  int m_total = 0;
  logic [W-1:0] data_base = '0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected write for the k-th accepted beat of the current load.
  function automatic exp_t model_entry(input int k);
    exp_t r;
    int wtot;
    wtot = BANKS * (m_line + 1) * (m_buf + 1);
    r.last = (k == m_total - 1);
    r.data = data_base + W'(k);
    if (k < wtot) begin
      r.bias  = 1'b0;
      r.bank  = k % BANKS;
      r.addr  = (k / BANKS) % (m_line + 1);
      r.buf_i = k / (BANKS * (m_line + 1));
    end else begin
      r.bias  = 1'b1;
      r.bank  = (k - wtot) % BBANKS;
      r.addr  = (k - wtot) / BBANKS;
      r.buf_i = 0;
    end
    return r;
  endfunction

  task automatic check_outputs(input bit had_beat, input bit exp_done);
    exp_t e;
    logic [N-1:0] exp_en;
    logic [N-1:0][BANKS-1:0] exp_wen;
    exp_en  = '0;
    exp_wen = '0;
    if (had_beat) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        e = q.pop_front();
        if (!e.bias) begin
          exp_en[e.buf_i]  = 1'b1;
          exp_wen[e.buf_i] = BANKS'(1) << e.bank;
          chk("wr_addr", write_port_addr[e.buf_i], e.addr);
          chk("wr_data", write_port_data_in[e.buf_i], e.data);
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
          chk("bias_en_idle", bias_write_port_enable, 0);
        end else begin
          chk("bias_en", bias_write_port_enable, 1);
          chk("bias_wen", bias_write_port_wen, BBANKS'(1) << e.bank);
          chk("bias_addr", bias_write_port_addr, e.addr);
          chk("bias_data", bias_write_port_data_in, e.data);
`endif
        end
      end
    end else begin
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
      chk("bias_en_idle", bias_write_port_enable, 0);
`endif
    end
    chk("wr_enable", write_port_enable, exp_en);
    chk("wr_wen", write_port_wen, exp_wen);
    chk("done", done, exp_done);
    chk("s_ready", s_ready, m_state == S_LOAD);
    chk("busy", busy, m_state == S_LOAD);
  endtask

  // One clock: predict what the DUT accepts, advance the model, then check.
  task automatic tick();
    bit beat;
    bit will_done;
    exp_t e;
    beat = resetn && s_valid && (m_state == S_LOAD) && !soft_clear;
    will_done = 1'b0;
    if (beat) begin
      e = model_entry(m_cnt);
      q.push_back(e);
      will_done = e.last;
      m_cnt++;
    end
    if (!resetn || soft_clear) begin
      m_state = S_IDLE;
    end else begin
      case (m_state)
        S_IDLE: if (start) begin
          m_line  = int'(cfg_line_count_m1);
          m_buf   = int'(cfg_buffer_count_m1);
          m_cnt   = 0;
          m_total = BANKS * (m_line + 1) * (m_buf + 1);
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
          m_bias  = int'(cfg_bias_count_m1);
          m_total = m_total + BBANKS * (m_bias + 1);
`endif
          m_state = S_LOAD;
        end
        S_LOAD: if (will_done) m_state = S_DONE;
        default: m_state = S_IDLE;
      endcase
    end
    @(posedge clk);
    #1;
    check_outputs(beat, will_done);
  endtask

  task automatic do_start(input int line_m1, input int buf_m1, input int bias_m1);
    cfg_line_count_m1   = LW'(line_m1);
    cfg_buffer_count_m1 = BW'(buf_m1);
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
    cfg_bias_count_m1   = BLW'(bias_m1);
`else
    if (bias_m1 != 0) $display("note: bias count ignored in this build");
`endif
    start   = 1'b1;
    s_valid = 1'b0;
    tick();
    start   = 1'b0;
  endtask

  // Offer beats until `upto` have been accepted; optionally toggle s_valid.
  task automatic feed(input int upto, input bit toggle);
    int guard;
    bit v;
    guard = 0;
    v = 1'b1;
    while (m_cnt < upto && m_state == S_LOAD && guard < 1000) begin
      s_valid = v;
      s_data  = data_base + W'(m_cnt);
      tick();
      if (toggle) v = !v;
      guard++;
    end
    s_valid = 1'b0;
    if (guard >= 1000) begin
      checks++;
      errors++;
      $error("FAIL feed_timeout observed=%0d expected=%0d", m_cnt, upto);
    end
    while (m_state == S_DONE) tick();
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_enable"}, write_port_enable, 0);
    chk({tag, "_wen"}, write_port_wen, 0);
    chk({tag, "_addr"}, write_port_addr, 0);
    chk({tag, "_data"}, write_port_data_in, 0);
    chk({tag, "_ready"}, s_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
    chk({tag, "_bias_en"}, bias_write_port_enable, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    soft_clear = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    cfg_line_count_m1 = '0;
    cfg_buffer_count_m1 = '0;
`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
    cfg_bias_count_m1 = '0;
`endif
    #12;
    zero_checks("reset");
    tick();
    resetn = 1'b1;
    tick();

    // Basic fill: 2 addresses x 8 banks into buffer 0.
    data_base = '0;
    do_start(1, 0, 0);
    feed(16, 1'b0);
    tick();

    // Buffer switch: one address per buffer across all six buffers.
    do_start(0, 5, 0);
    feed(48, 1'b0);

    // Gaps in s_valid must not skip or repeat any write.
    do_start(1, 0, 0);
    feed(16, 1'b1);

    // Start with a different cfg during the load is ignored.
    data_base = 64'h0000_0100;
    do_start(1, 0, 0);
    feed(5, 1'b0);
    cfg_line_count_m1   = LW'(0);
    cfg_buffer_count_m1 = BW'(5);
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = data_base + W'(m_cnt);
    tick();
    start = 1'b0;
    feed(16, 1'b0);

    // soft_clear after seven beats, then a fresh load from bank 0 addr 0.
    data_base = 64'hA5A5_0000_0000_0000;
    do_start(1, 0, 0);
    feed(7, 1'b0);
    soft_clear = 1'b1;
    s_valid    = 1'b1;
    s_data     = data_base + W'(m_cnt);
    tick();
    soft_clear = 1'b0;
    s_valid    = 1'b0;
    q.delete();
    tick();
    data_base = 64'h0000_0000_0000_0200;
    do_start(1, 0, 0);
    feed(16, 1'b0);

    // Reset in the middle of a load: outputs clear at once, no done follows.
    data_base = 64'hFFFF_0000_0000_0000;
    do_start(0, 1, 0);
    feed(4, 1'b0);
    s_valid = 1'b1;
    resetn  = 1'b0;
    #1;
    zero_checks("midreset");
    m_state = S_IDLE;
    q.delete();
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;

`ifdef WEIGHT_BUFFER_LOADER_BIAS_EN
    // Bias: 8 weight beats then 8 bias beats; done only after the last bias write.
    data_base = 64'h0000_0000_0000_0300;
    do_start(0, 0, 1);
    feed(16, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
